// File: rtl/rv4028_bus_pkg.sv
// rv4028_bus_pkg: shared FSM encoding, wait-counter width and lane polarity for the bus target
package rv4028_bus_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA} state_t;
  localparam int CNT_W = 4;
  localparam logic LANE_ON = 1'b0;
  localparam logic LANE_OFF = 1'b1;
endpackage

// File: rtl/rv4028_sram_bank.sv
// rv4028_sram_bank: 2^ADDR_BITS x 16 storage with synchronous read and byte-lane writes
module rv4028_sram_bank #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 re,
  input  logic [1:0]           we,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);
  logic [15:0] mem [1 << ADDR_BITS];
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0] <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/rv4028_bus_target.sv
// rv4028_bus_target: halfword bus target with read wait states and byte-lane writes
module rv4028_bus_target
  import rv4028_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 0,
  parameter int          IO_TARGET   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [1:0]  wr_n,
  input  logic        rd_n,
  input  logic [1:0]  msk_n,
  input  logic        iorq_n,
  input  logic [1:0]  mreq_n,
  output logic        wait_n,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rdata_oe
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ADDR_BITS-1:0] idx, word, mem_addr;
  logic [1:0] msk_q, we;
  logic [15:0] q;
  logic sel, wr_go, rd_go, wait_q, unused_bit0;
  assign unused_bit0 = addr[0];
  assign word = addr[ADDR_BITS:1];
  assign sel = (addr[31:ADDR_BITS+1] == BASE_ADDR[31:ADDR_BITS+1]) && (iorq_n == (IO_TARGET == 0));
  assign wr_go = (state == IDLE) && (wr_n == 2'b00) && !mreq_n[0] && sel;
  assign rd_go = (state == IDLE) && !rd_n && !mreq_n[1] && sel && !wr_go;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: begin
        state_n = wr_go ? WR_DATA : rd_go ? (WAIT_STATES == 0 ? RD_DATA : RD_WAIT) : IDLE;
        cnt_n = (rd_go && WAIT_STATES != 0) ? CNT_W'(WAIT_STATES - 1) : cnt;
      end
      RD_WAIT: begin
        state_n = (cnt == '0) ? RD_DATA : RD_WAIT;
        cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // wait_n is registered from the next state so it lines up with RD_WAIT without an input path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      wait_q <= 1'b1;
      idx <= '0;
      msk_q <= {2{LANE_OFF}};
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wait_q <= (state_n != RD_WAIT);
      if (wr_go || rd_go) idx <= word;
      if (wr_go) msk_q <= msk_n;
    end
  end
  assign mem_addr = (state == WR_DATA) ? idx : word;
  assign we = (state == WR_DATA) ? ~(msk_q ^ {2{LANE_ON}}) : 2'b00;
  rv4028_sram_bank #(.ADDR_BITS(ADDR_BITS)) u_bank (
    .clk(clk), .addr(mem_addr), .re(rd_go), .we(we), .wdata(wdata), .rdata(q)
  );
  assign wait_n = wait_q;
  assign rdata_oe = (state == RD_DATA);
  assign rdata = rdata_oe ? q : 16'h0000;
endmodule

// File: tb/tb_rv4028_bus_target.sv
// tb_rv4028_bus_target: scoreboard bench driving a zero-wait and a three-wait target on one shared bus
module tb_rv4028_bus_target;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0] wr_n = 2'b11, msk_n = 2'b11, mreq_n = 2'b11;
  logic rd_n = 1'b1, iorq_n = 1'b1;
  logic [15:0] wdata = '0, rdata0, rdata3;
  logic wait_n0, wait_n3, oe0, oe3;
  logic [15:0] q0[$], q3[$];
  int n_checks = 0, n_fail = 0, run3 = 0, low0 = 0, low3 = 0, low3_snap;
  logic prev_oe0 = 1'b0, prev_oe3 = 1'b0;

  always #5 clk = ~clk;

  rv4028_bus_target #(.BASE_ADDR(32'h1000_0000), .ADDR_BITS(10), .WAIT_STATES(0), .IO_TARGET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_n(wr_n), .rd_n(rd_n), .msk_n(msk_n), .iorq_n(iorq_n),
    .mreq_n(mreq_n), .wait_n(wait_n0), .wdata(wdata), .rdata(rdata0), .rdata_oe(oe0));
  rv4028_bus_target #(.BASE_ADDR(32'h1000_0000), .ADDR_BITS(10), .WAIT_STATES(3), .IO_TARGET(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_n(wr_n), .rd_n(rd_n), .msk_n(msk_n), .iorq_n(iorq_n),
    .mreq_n(mreq_n), .wait_n(wait_n3), .wdata(wdata), .rdata(rdata3), .rdata_oe(oe3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_idle();
    addr = '0; wr_n = 2'b11; rd_n = 1'b1; mreq_n = 2'b11; msk_n = 2'b11; iorq_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wait_n0"}, wait_n0, 1); chk({tag, "_oe0"}, oe0, 0); chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_wait_n3"}, wait_n3, 1); chk({tag, "_oe3"}, oe3, 0); chk({tag, "_rdata3"}, rdata3, 0);
  endtask

  task automatic write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] m, input logic io, input bit cut);
    @(posedge clk); #1;
    addr = a; wr_n = 2'b00; mreq_n = 2'b10; msk_n = m; wdata = d; iorq_n = io;
    @(posedge clk); #1;
    bus_idle();
    if (cut) begin
      rst_n = 1'b0;
      #1 chk_reset_outputs("rst_in_wr");
      @(posedge clk); #1 rst_n = 1'b1;
    end else @(posedge clk);
  endtask

  task automatic read(input logic [31:0] a);
    @(posedge clk); #1;
    addr = a; rd_n = 1'b0; mreq_n = 2'b01;
    @(posedge clk); #1;
    bus_idle();
    repeat (6) @(posedge clk);
  endtask

  // Monitor: pops the expected word whenever a target drives data
  always @(negedge clk) begin
    if (!wait_n0) low0++;
    if (!wait_n3) begin low3++; run3++; end
    if (oe0) begin
      chk("oe0_expected", q0.size() != 0, 1);
      if (q0.size() != 0) chk("rdata0", rdata0, q0.pop_front());
      chk("wait_n0_at_data", wait_n0, 1);
      chk("oe0_single", prev_oe0, 0);
    end
    if (oe3) begin
      chk("oe3_expected", q3.size() != 0, 1);
      if (q3.size() != 0) chk("rdata3", rdata3, q3.pop_front());
      chk("wait_n3_at_data", wait_n3, 1);
      chk("wait3_run", run3, 3);
      chk("oe3_single", prev_oe3, 0);
    end
    if (wait_n3) run3 = 0;
    prev_oe0 = oe0;
    prev_oe3 = oe3;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;
    write(32'h1000_0004, 16'hBEEF, 2'b00, 1'b1, 0);
    q0.push_back(16'hBEEF); q3.push_back(16'hBEEF);
    read(32'h1000_0004);
    write(32'h1000_0004, 16'h12AB, 2'b01, 1'b1, 0);
    q0.push_back(16'h12EF); q3.push_back(16'h12EF);
    read(32'h1000_0004);
    write(32'h1000_0000, 16'h1111, 2'b00, 1'b1, 0);
    write(32'h1000_0002, 16'h2222, 2'b00, 1'b1, 0);
    q0.push_back(16'h1111); q0.push_back(16'h2222); q3.push_back(16'h1111);
    @(posedge clk); #1;
    addr = 32'h1000_0000; rd_n = 1'b0; mreq_n = 2'b01;
    repeat (2) @(posedge clk);
    #1 addr = 32'h1000_0002;
    repeat (2) @(posedge clk);
    #1 bus_idle();
    repeat (6) @(posedge clk);
    low3_snap = low3;
    read(32'h2000_0000);
    chk("unsel_wait3_low", low3 - low3_snap, 0);
    @(posedge clk); #1;
    addr = 32'h1000_0006; wr_n = 2'b00; rd_n = 1'b0; mreq_n = 2'b00; msk_n = 2'b00; wdata = 16'h5A5A;
    @(posedge clk); #1 bus_idle();
    repeat (6) @(posedge clk);
    q0.push_back(16'h5A5A); q3.push_back(16'h5A5A);
    read(32'h1000_0006);
    write(32'h1000_0004, 16'hDEAD, 2'b00, 1'b0, 0);
    q0.push_back(16'h12EF); q3.push_back(16'h12EF);
    read(32'h1000_0004);
    write(32'h1000_0004, 16'hCAFE, 2'b00, 1'b1, 1);
    q0.push_back(16'h12EF); q3.push_back(16'h12EF);
    read(32'h1000_0004);
    q0.push_back(16'h12EF);
    @(posedge clk); #1;
    addr = 32'h1000_0004; rd_n = 1'b0; mreq_n = 2'b01;
    @(posedge clk); #1 bus_idle();
    @(posedge clk); #1;
    chk("rd_wait_before_rst", wait_n3, 0);
    rst_n = 1'b0;
    #1 chk_reset_outputs("rst_in_rdwait");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    q0.push_back(16'h12EF); q3.push_back(16'h12EF);
    read(32'h1000_0004);
    repeat (4) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q3_drained", q3.size(), 0);
    chk("wait_n0_never_low", low0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
